// File: rtl/feature_pkg.sv
// Shared constants, sqrt FSM encoding and magnitude helper for the feature pipeline.
package feature_pkg;

    localparam int unsigned MAG_W      = 16;
    localparam int unsigned SQRT_ITERS = 16;
    localparam int unsigned PIPE_LAT   = 20;

    typedef logic [1:0] sqrt_state_t;

    localparam sqrt_state_t SQRT_IDLE = 2'd0;
    localparam sqrt_state_t SQRT_RUN  = 2'd1;
    localparam sqrt_state_t SQRT_DONE = 2'd2;

    // |v| of a 16-bit two's-complement value; 17 bits so that |-32768| is exact.
    function automatic logic [MAG_W:0] abs17(input logic [MAG_W-1:0] v);
        return v[MAG_W-1] ? ({1'b0, ~v} + (MAG_W+1)'(1)) : {1'b0, v};
    endfunction

endpackage

// File: rtl/isqrt32.sv
// Restoring bit-serial integer square root: floor(sqrt(32-bit)) in 16 fixed iterations.
module isqrt32
    import feature_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] radicand,
    output logic        busy,
    output logic        done,
    output logic [15:0] root
);

    sqrt_state_t state_d, state_q;
    logic [31:0] op_d, op_q;
    logic [17:0] rem_d, rem_q;
    logic [15:0] root_d, root_q;
    logic [3:0]  iter_d, iter_q;
    logic [19:0] rem_shift;
    logic [19:0] trial;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        root_d    = root_q;
        iter_d    = iter_q;
        rem_shift = {rem_q, op_q[31:30]};
        trial     = {2'b00, root_q, 2'b01};
        case (state_q)
            SQRT_IDLE: begin
                if (start) begin
                    op_d    = radicand;
                    rem_d   = '0;
                    root_d  = '0;
                    iter_d  = '0;
                    state_d = SQRT_RUN;
                end
            end
            SQRT_RUN: begin
                op_d = {op_q[29:0], 2'b00};
                // Remainder never exceeds 2*root, so 18 bits always hold it.
                if (rem_shift >= trial) begin
                    rem_d  = 18'(rem_shift - trial);
                    root_d = {root_q[14:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[17:0];
                    root_d = {root_q[14:0], 1'b0};
                end
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(SQRT_ITERS - 1)) begin
                    state_d = SQRT_DONE;
                end
            end
            SQRT_DONE: state_d = SQRT_IDLE;
            default:   state_d = SQRT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= SQRT_IDLE;
            op_q    <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            iter_q  <= iter_d;
        end
    end

    assign busy = (state_q != SQRT_IDLE);
    assign done = (state_q == SQRT_DONE);
    assign root = root_q;

endmodule

// File: rtl/feature_pipeline.sv
// Accelerometer magnitude mean/std-dev extractor over 2**WINDOW_LOG2-sample windows.
// Optional FEATURE_ROUND_EN: round-to-nearest window mean instead of truncation.
module feature_pipeline
    import feature_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    output logic [15:0] feature_mean,
    output logic [15:0] feature_std,
    output logic        feature_valid
);

    localparam int unsigned SUM_W = MAG_W + WINDOW_LOG2;
    localparam int unsigned SQ_W  = 2 * MAG_W + WINDOW_LOG2;

    logic [17:0]            mag_raw;
    logic [MAG_W-1:0]       mag_d, mag_q;
    logic                   mag_vld_d, mag_vld_q;

    logic [WINDOW_LOG2-1:0] cnt_d, cnt_q;
    logic [SUM_W-1:0]       sum_d, sum_q, sum_ext;
    logic [SQ_W-1:0]        sumsq_d, sumsq_q, sumsq_ext;
    logic [31:0]            mag_sq;
    logic [15:0]            snap_mean_d, snap_mean_q;
    logic [31:0]            snap_ex2_d, snap_ex2_q;
    logic                   snap_vld_d, snap_vld_q;

    logic [31:0]            mean_sq;
    logic [31:0]            var_d, var_q;
    logic                   var_vld_d, var_vld_q;
    logic [15:0]            mean_pend_d, mean_pend_q;

    logic                   sqrt_busy, sqrt_done;
    logic [15:0]            sqrt_root;

    logic [15:0]            feature_mean_d, feature_mean_q;
    logic [15:0]            feature_std_d, feature_std_q;
    logic                   feature_valid_d, feature_valid_q;

`ifdef FEATURE_ROUND_EN
    logic [SUM_W:0]         sum_rnd;
    logic [MAG_W:0]         snap_rnd_d, snap_rnd_q;
`endif

    always_comb begin
        mag_raw   = 18'(abs17(accel_x)) + 18'(abs17(accel_y)) + 18'(abs17(accel_z));
        mag_d     = (mag_raw[17:16] != 2'b00) ? '1 : mag_raw[15:0];
        mag_vld_d = start;
    end

    // Only the shifted window quantities are snapshotted; low bits are never needed later.
    always_comb begin
        mag_sq      = 32'(mag_q) * 32'(mag_q);
        sum_ext     = sum_q + SUM_W'(mag_q);
        sumsq_ext   = sumsq_q + SQ_W'(mag_sq);
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sumsq_d     = sumsq_q;
        snap_mean_d = snap_mean_q;
        snap_ex2_d  = snap_ex2_q;
        snap_vld_d  = 1'b0;
`ifdef FEATURE_ROUND_EN
        sum_rnd     = {1'b0, sum_ext} + (SUM_W+1)'(1 << (WINDOW_LOG2 - 1));
        snap_rnd_d  = snap_rnd_q;
`endif
        if (mag_vld_q) begin
            if (cnt_q == '1) begin
                snap_mean_d = 16'(sum_ext >> WINDOW_LOG2);
                snap_ex2_d  = 32'(sumsq_ext >> WINDOW_LOG2);
`ifdef FEATURE_ROUND_EN
                snap_rnd_d  = (MAG_W+1)'(sum_rnd >> WINDOW_LOG2);
`endif
                snap_vld_d  = 1'b1;
                sum_d       = '0;
                sumsq_d     = '0;
                cnt_d       = '0;
            end else begin
                sum_d   = sum_ext;
                sumsq_d = sumsq_ext;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        mean_sq     = 32'(snap_mean_q) * 32'(snap_mean_q);
        var_d       = var_q;
        mean_pend_d = mean_pend_q;
        var_vld_d   = snap_vld_q;
        if (snap_vld_q) begin
            var_d = (snap_ex2_q >= mean_sq) ? (snap_ex2_q - mean_sq) : '0;
`ifdef FEATURE_ROUND_EN
            mean_pend_d = snap_rnd_q[MAG_W] ? '1 : snap_rnd_q[MAG_W-1:0];
`else
            mean_pend_d = snap_mean_q;
`endif
        end
    end

    isqrt32 u_isqrt (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (var_vld_q & ~sqrt_busy),
        .radicand (var_q),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );

    always_comb begin
        feature_mean_d  = feature_mean_q;
        feature_std_d   = feature_std_q;
        feature_valid_d = sqrt_done;
        if (sqrt_done) begin
            feature_mean_d = mean_pend_q;
            feature_std_d  = sqrt_root;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            mag_q           <= '0;
            mag_vld_q       <= 1'b0;
            cnt_q           <= '0;
            sum_q           <= '0;
            sumsq_q         <= '0;
            snap_mean_q     <= '0;
            snap_ex2_q      <= '0;
            snap_vld_q      <= 1'b0;
            var_q           <= '0;
            var_vld_q       <= 1'b0;
            mean_pend_q     <= '0;
            feature_mean_q  <= '0;
            feature_std_q   <= '0;
            feature_valid_q <= 1'b0;
`ifdef FEATURE_ROUND_EN
            snap_rnd_q      <= '0;
`endif
        end else begin
            mag_q           <= mag_d;
            mag_vld_q       <= mag_vld_d;
            cnt_q           <= cnt_d;
            sum_q           <= sum_d;
            sumsq_q         <= sumsq_d;
            snap_mean_q     <= snap_mean_d;
            snap_ex2_q      <= snap_ex2_d;
            snap_vld_q      <= snap_vld_d;
            var_q           <= var_d;
            var_vld_q       <= var_vld_d;
            mean_pend_q     <= mean_pend_d;
            feature_mean_q  <= feature_mean_d;
            feature_std_q   <= feature_std_d;
            feature_valid_q <= feature_valid_d;
`ifdef FEATURE_ROUND_EN
            snap_rnd_q      <= snap_rnd_d;
`endif
        end
    end

    assign feature_mean  = feature_mean_q;
    assign feature_std   = feature_std_q;
    assign feature_valid = feature_valid_q;

endmodule

// File: tb/tb_feature_pipeline.sv
// Directed self-checking bench for feature_pipeline (WINDOW_LOG2 = 5).
module tb_feature_pipeline;

    localparam int unsigned W = 5;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] accel_x, accel_y, accel_z;
    logic [15:0] feature_mean, feature_std;
    logic        feature_valid;

    int checks = 0;
    int errors = 0;

    int          rises = 0;
    int          high_cycles = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] pm [32];
    logic [15:0] ps [32];

    feature_pipeline #(.WINDOW_LOG2(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .accel_x       (accel_x),
        .accel_y       (accel_y),
        .accel_z       (accel_z),
        .feature_mean  (feature_mean),
        .feature_std   (feature_std),
        .feature_valid (feature_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts rising edges and high cycles, records results per pulse.
    always @(negedge clk) begin
        if (feature_valid === 1'b1) begin
            high_cycles++;
            if (prev_valid !== 1'b1) begin
                if (rises < 32) begin
                    pm[rises] = feature_mean;
                    ps[rises] = feature_std;
                end
                rises++;
            end
        end
        prev_valid = feature_valid;
    end

    task automatic reset_dut();
        start   = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        start   = 1'b1;
        accel_x = x;
        accel_y = y;
        accel_z = z;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (feature_valid === 1'b1 && lat < 0) lat = c;
        end
    endtask

    task automatic test_reset();
        start   = 1'b0;
        accel_x = '0;
        accel_y = '0;
        accel_z = '0;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (feature_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", feature_valid); end
        checks++;
        if (feature_mean !== 16'd0) begin errors++; $display("FAIL reset_mean: got %0d want 0", feature_mean); end
        checks++;
        if (feature_std !== 16'd0) begin errors++; $display("FAIL reset_std: got %0d want 0", feature_std); end
        reset_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_constant();
        int lat;
        int r0;
        reset_dut();
        r0 = rises;
        for (int i = 0; i < 32; i++) send(16'd100, -16'sd50, 16'd0);
        wait_pulse(lat);
        checks++;
        if (lat != 20) begin errors++; $display("FAIL const_latency: got %0d want 20", lat); end
        checks++;
        if (rises - r0 != 1) begin errors++; $display("FAIL const_pulses: got %0d want 1", rises - r0); end
        checks++;
        if (pm[r0] !== 16'd150) begin errors++; $display("FAIL const_mean: got %0d want 150", pm[r0]); end
        checks++;
        if (ps[r0] !== 16'd0) begin errors++; $display("FAIL const_std: got %0d want 0", ps[r0]); end
        checks++;
        if (feature_mean !== 16'd150 || feature_valid !== 1'b0) begin
            errors++;
            $display("FAIL const_hold: got mean=%0d valid=%b want 150/0", feature_mean, feature_valid);
        end
    endtask

    task automatic test_alternate();
        int lat;
        int r0;
        reset_dut();
        r0 = rises;
        for (int i = 0; i < 32; i++) send((i % 2 == 0) ? 16'd0 : 16'd200, 16'd0, 16'd0);
        wait_pulse(lat);
        checks++;
        if (rises - r0 != 1) begin errors++; $display("FAIL alt_pulses: got %0d want 1", rises - r0); end
        checks++;
        if (pm[r0] !== 16'd100) begin errors++; $display("FAIL alt_mean: got %0d want 100", pm[r0]); end
        checks++;
        if (ps[r0] !== 16'd100) begin errors++; $display("FAIL alt_std: got %0d want 100", ps[r0]); end
    endtask

    task automatic test_saturate();
        int lat;
        int r0;
        reset_dut();
        r0 = rises;
        for (int i = 0; i < 32; i++) send(16'h8000, 16'h8000, 16'h8000);
        wait_pulse(lat);
        checks++;
        if (rises - r0 != 1) begin errors++; $display("FAIL sat_pulses: got %0d want 1", rises - r0); end
        checks++;
        if (pm[r0] !== 16'd65535) begin errors++; $display("FAIL sat_mean: got %0d want 65535", pm[r0]); end
        checks++;
        if (ps[r0] !== 16'd0) begin errors++; $display("FAIL sat_std: got %0d want 0", ps[r0]); end
    endtask

    task automatic test_abs_min();
        int lat;
        int r0;
        reset_dut();
        r0 = rises;
        for (int i = 0; i < 32; i++) send(16'h8000, 16'd0, 16'd0);
        wait_pulse(lat);
        checks++;
        if (pm[r0] !== 16'd32768) begin errors++; $display("FAIL absmin_mean: got %0d want 32768", pm[r0]); end
        checks++;
        if (ps[r0] !== 16'd0) begin errors++; $display("FAIL absmin_std: got %0d want 0", ps[r0]); end
    endtask

    task automatic test_rounding();
        int lat;
        int r0;
        logic [15:0] exp_mean;
`ifdef FEATURE_ROUND_EN
        exp_mean = 16'd2;
`else
        exp_mean = 16'd1;
`endif
        reset_dut();
        r0 = rises;
        for (int i = 0; i < 32; i++) send((i % 2 == 0) ? 16'd1 : 16'd2, 16'd0, 16'd0);
        wait_pulse(lat);
        checks++;
        if (rises - r0 != 1) begin errors++; $display("FAIL round_pulses: got %0d want 1", rises - r0); end
        checks++;
        if (pm[r0] !== exp_mean) begin errors++; $display("FAIL round_mean: got %0d want %0d", pm[r0], exp_mean); end
        checks++;
        if (ps[r0] !== 16'd1) begin errors++; $display("FAIL round_std: got %0d want 1", ps[r0]); end
    endtask

    task automatic test_mid_reset();
        int lat;
        int r0;
        reset_dut();
        r0 = rises;
        for (int i = 0; i < 20; i++) send(16'd7, 16'd0, 16'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        for (int i = 0; i < 32; i++) send(16'd10, 16'd0, 16'd0);
        wait_pulse(lat);
        checks++;
        if (rises - r0 != 1) begin errors++; $display("FAIL midrst_pulses: got %0d want 1", rises - r0); end
        checks++;
        if (lat != 20) begin errors++; $display("FAIL midrst_latency: got %0d want 20", lat); end
        checks++;
        if (pm[r0] !== 16'd10) begin errors++; $display("FAIL midrst_mean: got %0d want 10", pm[r0]); end
        checks++;
        if (ps[r0] !== 16'd0) begin errors++; $display("FAIL midrst_std: got %0d want 0", ps[r0]); end
    endtask

    function automatic longint floor_sqrt(input longint v);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    task automatic test_random_gaps();
        int          r0, h0, k, nwin;
        longint      s, sq, mt, ex2, v, m;
        int          ax, ay, az;
        logic [15:0] xv, yv, zv;
        longint      exp_m [3];
        longint      exp_s [3];
        reset_dut();
        r0 = rises;
        h0 = high_cycles;
        s = 0; sq = 0; k = 0; nwin = 0;
        for (int i = 0; i < 100; i++) begin
            xv = 16'($urandom);
            yv = 16'($urandom);
            zv = 16'($urandom);
            ax = int'($signed(xv)); if (ax < 0) ax = -ax;
            ay = int'($signed(yv)); if (ay < 0) ay = -ay;
            az = int'($signed(zv)); if (az < 0) az = -az;
            m = longint'(ax + ay + az);
            if (m > 65535) m = 65535;
            s += m;
            sq += m * m;
            k++;
            if (k == 32) begin
                mt  = s / 32;
                ex2 = sq / 32;
                v   = ex2 - mt * mt;
                if (v < 0) v = 0;
`ifdef FEATURE_ROUND_EN
                exp_m[nwin] = (s + 16) / 32;
                if (exp_m[nwin] > 65535) exp_m[nwin] = 65535;
`else
                exp_m[nwin] = mt;
`endif
                exp_s[nwin] = floor_sqrt(v);
                nwin++;
                s = 0; sq = 0; k = 0;
            end
            send(xv, yv, zv);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        repeat (80) @(posedge clk);
        #1;
        checks++;
        if (rises - r0 != 3) begin errors++; $display("FAIL rand_pulses: got %0d want 3", rises - r0); end
        checks++;
        if (high_cycles - h0 != 3) begin errors++; $display("FAIL rand_width: got %0d high cycles want 3", high_cycles - h0); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (longint'(pm[r0 + j]) != exp_m[j]) begin
                errors++;
                $display("FAIL rand_mean[%0d]: got %0d want %0d", j, pm[r0 + j], exp_m[j]);
            end
            checks++;
            if (longint'(ps[r0 + j]) != exp_s[j]) begin
                errors++;
                $display("FAIL rand_std[%0d]: got %0d want %0d", j, ps[r0 + j], exp_s[j]);
            end
        end
    endtask

    initial begin
        start   = 1'b0;
        reset_n = 1'b1;
        accel_x = '0;
        accel_y = '0;
        accel_z = '0;
        test_reset();
        test_constant();
        test_alternate();
        test_saturate();
        test_abs_min();
        test_rounding();
        test_mid_reset();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
